alarm_clock: RTL and testbench

- 24-hour BCD alarm clock: keeps HH:MM:SS time, holds a programmable HH:MM alarm, and raises a sticky Alarm flag on a match.
- Time and alarm are loaded from BCD digit inputs.
- Sits between the time-configuration interface (load/readout digits) and the alarm-operation interface (AL_ON, STOP_al, Alarm).
- Seconds advance from a tick derived by dividing the system clock.

---
 rtl/alarm_clock.sv | 175 +++++++++++++++++
 tb/tb_alarm_clock.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock.sv
// ============================================================================
// Module   : alarm_clock
// Brief    : 24-hour BCD HH:MM:SS clock with a programmable HH:MM sticky alarm
// Revision : 1.0
// ============================================================================
`default_nettype none

module alarm_clock #(
    parameter int CLK_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic       STOP_al,
    input  logic       AL_ON,
    output logic       Alarm,
    output logic [1:0] H_out1,
    output logic [3:0] H_out0,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0
);

    localparam int c_DIV_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_PER_SEC - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);

    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_h1;
    logic [3:0]         r_h0;
    logic [3:0]         r_m1;
    logic [3:0]         r_m0;
    logic [3:0]         r_s1;
    logic [3:0]         r_s0;
    logic [1:0]         r_al_h1;
    logic [3:0]         r_al_h0;
    logic [3:0]         r_al_m1;
    logic [3:0]         r_al_m0;
    logic               r_alarm;

    logic w_legal;
    logic w_tick;
    logic w_ld_time;
    logic w_ld_alarm;
    logic w_match;
    logic w_s0_wrap;
    logic w_s1_wrap;
    logic w_m0_wrap;
    logic w_m1_wrap;
    logic w_h_wrap;
    logic w_inc_s1;
    logic w_inc_m0;
    logic w_inc_m1;
    logic w_inc_h;

    always_comb begin
        w_legal    = (((H_in1 < 2'd2) && (H_in0 <= 4'd9)) ||
                      ((H_in1 == 2'd2) && (H_in0 <= 4'd3))) &&
                     (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
        w_tick     = (r_div == c_DIV_MAX);
        w_ld_time  = LD_time && w_legal;
        w_ld_alarm = LD_alarm && w_legal;

        w_s0_wrap  = (r_s0 == 4'd9);
        w_s1_wrap  = (r_s1 == 4'd5);
        w_m0_wrap  = (r_m0 == 4'd9);
        w_m1_wrap  = (r_m1 == 4'd5);
        w_h_wrap   = (r_h1 == 2'd2) && (r_h0 == 4'd3);

        // Ripple carry: each digit advances only when all lower digits wrap.
        w_inc_s1   = w_tick && w_s0_wrap;
        w_inc_m0   = w_inc_s1 && w_s1_wrap;
        w_inc_m1   = w_inc_m0 && w_m0_wrap;
        w_inc_h    = w_inc_m1 && w_m1_wrap;

        w_match    = AL_ON &&
                     (r_h1 == r_al_h1) && (r_h0 == r_al_h0) &&
                     (r_m1 == r_al_m1) && (r_m0 == r_al_m0) &&
                     (r_s1 == 4'd0) && (r_s0 == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset || w_ld_time) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h1 <= w_legal ? H_in1 : 2'd0;
            r_h0 <= w_legal ? H_in0 : 4'd0;
            r_m1 <= w_legal ? M_in1 : 4'd0;
            r_m0 <= w_legal ? M_in0 : 4'd0;
            r_s1 <= 4'd0;
            r_s0 <= 4'd0;
        end else if (w_ld_time) begin
            r_h1 <= H_in1;
            r_h0 <= H_in0;
            r_m1 <= M_in1;
            r_m0 <= M_in0;
            r_s1 <= 4'd0;
            r_s0 <= 4'd0;
        end else begin
            if (w_tick) begin
                r_s0 <= w_s0_wrap ? 4'd0 : r_s0 + 4'd1;
            end
            if (w_inc_s1) begin
                r_s1 <= w_s1_wrap ? 4'd0 : r_s1 + 4'd1;
            end
            if (w_inc_m0) begin
                r_m0 <= w_m0_wrap ? 4'd0 : r_m0 + 4'd1;
            end
            if (w_inc_m1) begin
                r_m1 <= w_m1_wrap ? 4'd0 : r_m1 + 4'd1;
            end
            if (w_inc_h) begin
                if (w_h_wrap) begin
                    r_h1 <= 2'd0;
                    r_h0 <= 4'd0;
                end else if (r_h0 == 4'd9) begin
                    r_h1 <= r_h1 + 2'd1;
                    r_h0 <= 4'd0;
                end else begin
                    r_h0 <= r_h0 + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_al_h1 <= w_legal ? H_in1 : 2'd0;
            r_al_h0 <= w_legal ? H_in0 : 4'd0;
            r_al_m1 <= w_legal ? M_in1 : 4'd0;
            r_al_m0 <= w_legal ? M_in0 : 4'd0;
        end else if (w_ld_alarm) begin
            r_al_h1 <= H_in1;
            r_al_h0 <= H_in0;
            r_al_m1 <= M_in1;
            r_al_m0 <= M_in0;
        end
    end

    // Clear beats set, so holding STOP_al masks the alarm for the matching second.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm <= 1'b0;
        end else if (STOP_al || !AL_ON) begin
            r_alarm <= 1'b0;
        end else if (w_match) begin
            r_alarm <= 1'b1;
        end
    end

    assign Alarm  = r_alarm;
    assign H_out1 = r_h1;
    assign H_out0 = r_h0;
    assign M_out1 = r_m1;
    assign M_out0 = r_m0;
    assign S_out1 = r_s1;
    assign S_out0 = r_s0;

endmodule

`default_nettype wire

// File: tb/tb_alarm_clock.sv
// ============================================================================
// Module   : tb_alarm_clock
// Brief    : directed stimulus with a cycle-stamped scoreboard for alarm_clock
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_clock;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       AL_ON;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [3:0] M_out1;
    logic [3:0] M_out0;
    logic [3:0] S_out1;
    logic [3:0] S_out0;

    alarm_clock #(.CLK_PER_SEC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .H_in1    (H_in1),
        .H_in0    (H_in0),
        .M_in1    (M_in1),
        .M_in0    (M_in0),
        .LD_time  (LD_time),
        .LD_alarm (LD_alarm),
        .STOP_al  (STOP_al),
        .AL_ON    (AL_ON),
        .Alarm    (Alarm),
        .H_out1   (H_out1),
        .H_out0   (H_out0),
        .M_out1   (M_out1),
        .M_out0   (M_out0),
        .S_out1   (S_out1),
        .S_out0   (S_out0)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        string       name;
        bit          chk_t;
        logic [23:0] t;
        bit          chk_a;
        logic        a;
    } sb_entry_t;

    sb_entry_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [23:0] bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic exp_t(input int d, input string nm, input int h, input int m, input int s);
        sb_entry_t e;
        e.at = cyc + d; e.name = nm; e.chk_t = 1'b1; e.t = bcd(h, m, s);
        e.chk_a = 1'b0; e.a = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_a(input int d, input string nm, input logic a);
        sb_entry_t e;
        e.at = cyc + d; e.name = nm; e.chk_t = 1'b0; e.t = '0;
        e.chk_a = 1'b1; e.a = a;
        sb.push_back(e);
    endtask

    // Outputs only move on posedge, so the negedge view is stable.
    always @(negedge clk) begin : monitor
        sb_entry_t   e;
        logic [23:0] got_t;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            vectors++;
            got_t = {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
            if (e.at != cyc) begin
                miscompares++;
                $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.at);
            end else if ((e.chk_t && got_t !== e.t) || (e.chk_a && Alarm !== e.a)) begin
                miscompares++;
                $display("FAIL %s at cycle %0d: got time %h alarm %b, required time %h alarm %b",
                         e.name, cyc, got_t, Alarm, e.chk_t ? e.t : got_t, e.chk_a ? e.a : Alarm);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_digits(input int h1, input int h0, input int m1, input int m0);
        H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
    endtask

    task automatic load_time(input int h, input int m, input string nm);
        set_digits(h / 10, h % 10, m / 10, m % 10);
        LD_time = 1'b1;
        exp_t(1, nm, h, m, 0);
        step(1);
        LD_time = 1'b0;
    endtask

    task automatic load_alarm(input int h, input int m);
        set_digits(h / 10, h % 10, m / 10, m % 10);
        LD_alarm = 1'b1;
        step(1);
        LD_alarm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; AL_ON = 1'b0;
        set_digits(1, 2, 3, 4);
        exp_t(1, "reset time", 12, 34, 0);
        exp_a(1, "reset alarm", 1'b0);
        step(1);
        reset = 1'b0;
        exp_t(9, "before first tick", 12, 34, 0);
        exp_t(10, "first tick", 12, 34, 1);
        step(10);

        // Rollovers
        load_time(23, 59, "load 23:59");
        exp_t(590, "23:59:59", 23, 59, 59);
        exp_t(600, "midnight wrap", 0, 0, 0);
        step(600);
        load_time(9, 59, "load 09:59");
        exp_t(600, "09 to 10 carry", 10, 0, 0);
        step(600);
        load_time(19, 59, "load 19:59");
        exp_t(600, "19 to 20 carry", 20, 0, 0);
        step(600);

        // Illegal loads ignored, counting undisturbed
        exp_t(1, "illegal 25:70 ignored", 20, 0, 0);
        exp_t(10, "count after illegal", 20, 0, 1);
        LD_time = 1'b1;
        set_digits(2, 5, 7, 0); step(1);
        set_digits(2, 4, 0, 0); step(1);
        set_digits(1, 9, 6, 0); step(1);
        LD_time = 1'b0;
        step(10);

        // Alarm set, STOP hold/re-arm, STOP clear
        AL_ON = 1'b1;
        load_alarm(10, 1);
        load_time(10, 0, "load 10:00");
        exp_t(599, "10:00:59", 10, 0, 59);
        exp_t(600, "10:01:00", 10, 1, 0);
        exp_a(600, "alarm not yet", 1'b0);
        exp_a(601, "alarm set", 1'b1);
        step(601);
        STOP_al = 1'b1;
        exp_a(1, "stop held 1", 1'b0);
        exp_a(2, "stop held 2", 1'b0);
        exp_a(3, "re-arm after stop", 1'b1);
        step(2);
        STOP_al = 1'b0;
        step(1);
        exp_t(46, "10:01:05", 10, 1, 5);
        exp_a(46, "alarm sticky", 1'b1);
        step(46);
        STOP_al = 1'b1;
        exp_a(1, "stop clears", 1'b0);
        exp_a(50, "stays cleared", 1'b0);
        step(1);
        STOP_al = 1'b0;
        step(50);

        // AL_ON low, then raised mid-minute
        AL_ON = 1'b0;
        load_alarm(10, 1);
        load_time(10, 0, "load 10:00 again");
        exp_t(600, "10:01:00 again", 10, 1, 0);
        exp_a(601, "al_on off no alarm", 1'b0);
        exp_a(605, "al_on off still 0", 1'b0);
        step(630);
        AL_ON = 1'b1;
        exp_a(1, "late al_on no alarm", 1'b0);
        exp_t(20, "10:01:05 again", 10, 1, 5);
        exp_a(20, "late al_on still 0", 1'b0);
        step(20);

        // Load collides with tick; combined time+alarm load
        load_time(5, 30, "load 05:30");
        exp_t(9, "05:30 before tick", 5, 30, 0);
        step(9);
        set_digits(0, 7, 4, 5);
        LD_time = 1'b1; LD_alarm = 1'b1;
        exp_t(1, "load beats tick", 7, 45, 0);
        exp_a(1, "no match before load", 1'b0);
        exp_a(2, "both regs loaded", 1'b1);
        step(1);
        LD_time = 1'b0; LD_alarm = 1'b0;
        step(4);
        load_time(8, 0, "load 08:00 mid-phase");
        exp_t(9, "divider restart hold", 8, 0, 0);
        exp_t(10, "divider restart tick", 8, 0, 1);
        step(12);

        // Reset mid-count
        set_digits(1, 2, 3, 4);
        reset = 1'b1;
        exp_t(1, "reset mid-count", 12, 34, 0);
        exp_a(1, "reset clears alarm", 1'b0);
        exp_a(2, "match after reset", 1'b1);
        exp_t(10, "reset phase hold", 12, 34, 0);
        exp_t(11, "reset phase tick", 12, 34, 1);
        step(1);
        reset = 1'b0;
        step(11);

        for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
